gi2c_mini_nes_poller: RTL and testbench
=======================================

// Module: gI2C_mini_nes_poller
// PURPOSE
//  Scheduler for gI2C_mini_nes_read: issues periodic one-cycle request_data pulses and supervises each read with a timeout.
//  Retries failed reads, latches the 9 button bits and emits per-button press/release strobes for game logic.
//  Sits between the I2C read engine and the application; the application never drives the reader directly.
// PARAMETERS
//  POLL_TICKS     800000  clk_40 cycles between poll starts (50 Hz at 40 MHz); must be >= TIMEOUT_TICKS+4
//  TIMEOUT_TICKS  40000   max cycles from request pulse to rd_valid before the attempt fails
//  MAX_RETRIES    2       extra attempts after a failed read within one poll slot (0..7)
// PORTS
//  clk_40       in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  enable       in   1  1 = periodic polling runs; 0 = finish current slot, then stay idle
//  poll_now     in   1  one-shot request for an immediate poll; honoured only in S_IDLE
//  rd_request   out  1  to reader request_data; exactly one-cycle pulse per attempt
//  rd_busy      in   1  from reader busy
//  rd_valid     in   1  from reader data_valid
//  rd_buttons   in   9  from reader {none,up,down,left,right,B,A,select,start}
//  buttons      out  9  last good sample, same bit order
//  pressed      out  9  one-cycle strobe, bit set where a button went 0->1
//  released     out  9  one-cycle strobe, bit set where a button went 1->0
//  update       out  1  one-cycle strobe coincident with pressed/released
//  link_ok      out  1  1 after a good read; 0 after a slot exhausts all retries
//  err_count    out  8  failed slots, saturates at 255
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0 except buttons=9'h100 (btn_none); counters cleared; state S_IDLE.
//  Tick counter: free-running 0..POLL_TICKS-1 while enable=1; terminal count raises slot_due; cleared while enable=0.
//  States:
//   S_IDLE   : slot_due or poll_now, and rd_busy=0 -> S_REQ, retry count=0. Neither asserted -> stay.
//   S_REQ    : rd_request=1 for this cycle only; timeout counter cleared -> S_WAIT.
//   S_WAIT   : rd_valid=1 -> S_CAP. Timeout count reaches TIMEOUT_TICKS -> S_FAIL.
//   S_CAP    : buttons<=rd_buttons; pressed=rd_buttons&~buttons_old; released=~rd_buttons&buttons_old.
//              update=1 and link_ok<=1 in the same cycle -> S_IDLE.
//   S_FAIL   : retries<MAX_RETRIES -> S_HOLD (retry++). Else err_count++ (sat), link_ok<=0, buttons kept -> S_IDLE.
//   S_HOLD   : wait until rd_busy=0 -> S_REQ; never re-request while reader is busy.
//  Latency: rd_request is 1 cycle after the S_IDLE trigger; update is 1 cycle after rd_valid.
//  rd_valid outside S_WAIT is ignored; no capture and no strobes are produced.
//  slot_due arriving while not in S_IDLE is dropped, not queued; one poll in flight at a time.
//  poll_now and slot_due in the same cycle start a single poll.
//  enable 1->0 mid-slot: the current slot completes normally; no new slot starts.
//  Async reset mid-transaction: FSM returns to S_IDLE immediately; a late rd_valid is ignored.
//  pressed/released/update are 0 in every cycle other than S_CAP.
// TESTING
//  1 Reset, enable=1, POLL_TICKS=100, reader model returns 9'h084 at 30 cycles -> one rd_request per 100 cycles; buttons=9'h084.
//  2 Sample 9'h084, then 9'h00C -> pressed=9'h008, released=9'h080, update=1, all for one cycle.
//  3 Reader never asserts rd_valid, MAX_RETRIES=2 -> 3 rd_request pulses, then err_count=1, link_ok=0; buttons unchanged.
//  4 Hold rd_busy=1 in S_HOLD for 50 cycles -> no rd_request until rd_busy=0; then exactly 1 pulse.
//  5 enable=0, poll_now pulse -> exactly one read; poll_now pulsed during S_WAIT -> ignored.
//  6 rst_n low during S_WAIT, then rd_valid -> outputs at reset values; no update strobe.

Source files
------------

// File: rtl/gi2c_mini_nes_poller.sv
// Poll scheduler for the mini NES I2C reader: periodic requests, timeout,
// retries, button latch and per-button press/release strobes.
module gi2c_mini_nes_poller #(
    parameter int POLL_TICKS    = 800000,
    parameter int TIMEOUT_TICKS = 40000,
    parameter int MAX_RETRIES   = 2
) (
    input  logic       clk_40,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       poll_now,
    output logic       rd_request,
    input  logic       rd_busy,
    input  logic       rd_valid,
    input  logic [8:0] rd_buttons,
    output logic [8:0] buttons,
    output logic [8:0] pressed,
    output logic [8:0] released,
    output logic       update,
    output logic       link_ok,
    output logic [7:0] err_count
);

    localparam int TW  = $clog2(POLL_TICKS);
    localparam int TOW = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CAP,
        S_FAIL,
        S_HOLD
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [TW-1:0]  r_tick;
    logic [TOW-1:0] r_to;
    logic [2:0]     r_retry;
    logic [8:0]     r_sample;
    logic           w_slot_due;
    logic           w_timeout;
    logic           w_can_retry;

    assign w_slot_due  = enable && (r_tick == TW'(POLL_TICKS - 1));
    assign w_timeout   = (r_to == TOW'(TIMEOUT_TICKS - 1));
    assign w_can_retry = (r_retry < 3'(MAX_RETRIES));

    always_ff @(posedge clk_40 or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= '0;
        end else if (!enable || w_slot_due) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + TW'(1);
        end
    end

    always_ff @(posedge clk_40 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        rd_request = 1'b0;
        update     = 1'b0;
        pressed    = '0;
        released   = '0;
        unique case (r_state)
            S_IDLE: begin
                if ((w_slot_due || poll_now) && !rd_busy) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                rd_request = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (rd_valid) begin
                    w_next = S_CAP;
                end else if (w_timeout) begin
                    w_next = S_FAIL;
                end
            end
            S_CAP: begin
                update   = 1'b1;
                pressed  = r_sample & ~buttons;
                released = ~r_sample & buttons;
                w_next   = S_IDLE;
            end
            S_FAIL: begin
                w_next = w_can_retry ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!rd_busy) begin
                    w_next = S_REQ;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // rd_valid is only a pulse, so the sample is held until S_CAP commits it
    always_ff @(posedge clk_40 or negedge rst_n) begin
        if (!rst_n) begin
            r_to      <= '0;
            r_retry   <= '0;
            r_sample  <= '0;
            buttons   <= 9'h100;
            link_ok   <= 1'b0;
            err_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_retry <= '0;
                S_REQ:  r_to <= '0;
                S_WAIT: begin
                    r_to <= r_to + TOW'(1);
                    if (rd_valid) begin
                        r_sample <= rd_buttons;
                    end
                end
                S_CAP: begin
                    buttons <= r_sample;
                    link_ok <= 1'b1;
                end
                S_FAIL: begin
                    if (w_can_retry) begin
                        r_retry <= r_retry + 3'd1;
                    end else begin
                        link_ok <= 1'b0;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gi2c_mini_nes_poller.sv
// Scoreboard bench for the NES poller: a scripted reader answers requests,
// expected samples are queued and checked when update fires.
module tb_gi2c_mini_nes_poller;

    logic       clk_40 = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       poll_now = 1'b0;
    logic       rd_busy = 1'b0;
    logic       rd_valid = 1'b0;
    logic [8:0] rd_buttons = '0;
    logic       rd_request;
    logic [8:0] buttons;
    logic [8:0] pressed;
    logic [8:0] released;
    logic       update;
    logic       link_ok;
    logic [7:0] err_count;

    gi2c_mini_nes_poller #(
        .POLL_TICKS   (100),
        .TIMEOUT_TICKS(40),
        .MAX_RETRIES  (2)
    ) dut (
        .clk_40    (clk_40),
        .rst_n     (rst_n),
        .enable    (enable),
        .poll_now  (poll_now),
        .rd_request(rd_request),
        .rd_busy   (rd_busy),
        .rd_valid  (rd_valid),
        .rd_buttons(rd_buttons),
        .buttons   (buttons),
        .pressed   (pressed),
        .released  (released),
        .update    (update),
        .link_ok   (link_ok),
        .err_count (err_count)
    );

    always #5 clk_40 = ~clk_40;

    typedef struct packed {
        logic [8:0] b;
        logic [8:0] p;
        logic [8:0] r;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [8:0] model_btn = 9'h100;
    logic [8:0] btn_exp = '0;
    logic       btn_pend = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         req_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_40) begin
        cyc++;
        if (rd_request) req_cyc.push_back(cyc);
        if (btn_pend) begin
            chk("buttons", 32'(buttons), 32'(btn_exp));
            chk("link_ok_set", 32'(link_ok), 1);
            btn_pend = 1'b0;
        end
        if (!update && (pressed != 0 || released != 0))
            chk("strobe_idle", 32'({pressed, released}), 0);
        if (update) begin
            if (sb.size() == 0) begin
                chk("spurious_upd", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pressed", 32'(pressed), 32'(e.p));
                chk("released", 32'(released), 32'(e.r));
                btn_exp  = e.b;
                btn_pend = 1'b1;
            end
        end
    end

    task automatic push_exp(input logic [8:0] d);
        exp_t x;
        x.b = d;
        x.p = d & ~model_btn;
        x.r = ~d & model_btn;
        model_btn = d;
        sb.push_back(x);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk_40);
            if (rd_request) ok = 1'b1;
        end
        if (!ok) chk("req_timeout", 0, 1);
    endtask

    task automatic serve(input logic [8:0] d, input int lat);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        rd_busy = 1'b1;
        repeat (lat) @(negedge clk_40);
        rd_buttons = d;
        rd_valid = 1'b1;
        push_exp(d);
        @(negedge clk_40);
        rd_valid = 1'b0;
        rd_busy = 1'b0;
        @(negedge clk_40);
    endtask

    task automatic pulse_now();
        poll_now = 1'b1;
        @(posedge clk_40);
        #1 poll_now = 1'b0;
    endtask

    initial begin
        bit ok;
        int base;
        repeat (3) @(negedge clk_40);
        chk("rst_buttons", 32'(buttons), 32'h100);
        chk("rst_link", 32'(link_ok), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_req", 32'(rd_request), 0);
        chk("rst_upd", 32'(update), 0);
        rst_n = 1'b1;
        @(negedge clk_40);
        enable = 1'b1;

        serve(9'h084, 30);
        serve(9'h00C, 30);
        repeat (3) @(negedge clk_40);
        if (req_cyc.size() < 2) chk("period_n", req_cyc.size(), 2);
        else chk("period", req_cyc[1] - req_cyc[0], 100);

        base = req_cyc.size();
        wait_req(ok);
        enable = 1'b0;
        repeat (250) @(negedge clk_40);
        chk("retry_reqs", req_cyc.size() - base, 3);
        chk("fail_err", 32'(err_count), 1);
        chk("fail_link", 32'(link_ok), 0);
        chk("fail_btn", 32'(buttons), 32'h00C);

        base = req_cyc.size();
        pulse_now();
        wait_req(ok);
        rd_busy = 1'b1;
        repeat (45) @(negedge clk_40);
        chk("hold_reqs", req_cyc.size() - base, 1);
        repeat (50) @(negedge clk_40);
        chk("hold_busy", req_cyc.size() - base, 1);
        rd_busy = 1'b0;
        serve(9'h003, 5);
        repeat (3) @(negedge clk_40);
        chk("hold_total", req_cyc.size() - base, 2);
        chk("hold_err", 32'(err_count), 1);

        base = req_cyc.size();
        pulse_now();
        wait_req(ok);
        repeat (5) @(negedge clk_40);
        pulse_now();
        repeat (5) @(negedge clk_40);
        rd_buttons = 9'h110;
        rd_valid = 1'b1;
        push_exp(9'h110);
        @(negedge clk_40);
        rd_valid = 1'b0;
        repeat (150) @(negedge clk_40);
        chk("now_reqs", req_cyc.size() - base, 1);
        rd_buttons = 9'h1FF;
        rd_valid = 1'b1;
        @(negedge clk_40);
        rd_valid = 1'b0;
        repeat (3) @(negedge clk_40);
        chk("stray_btn", 32'(buttons), 32'h110);

        pulse_now();
        wait_req(ok);
        repeat (5) @(negedge clk_40);
        rst_n = 1'b0;
        #1;
        chk("arst_btn", 32'(buttons), 32'h100);
        chk("arst_link", 32'(link_ok), 0);
        chk("arst_err", 32'(err_count), 0);
        model_btn = 9'h100;
        @(negedge clk_40);
        @(negedge clk_40);
        rst_n = 1'b1;
        rd_buttons = 9'h0F0;
        rd_valid = 1'b1;
        @(negedge clk_40);
        rd_valid = 1'b0;
        repeat (5) @(negedge clk_40);
        chk("late_btn", 32'(buttons), 32'h100);
        chk("late_link", 32'(link_ok), 0);
        chk("late_upd", 32'(update), 0);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
